// File: rtl/shift_execute_stage.sv
// shift_execute_stage: two-stage pipelined SLL/SRL/SRA unit with valid/ready
// handshaking on both sides. Left shifts reuse the right barrel shifter by
// reversing the operand on entry to S1 and reversing the result again into S2.

// Right barrel shifter: log2(WIDTH) conditional stages, sign or zero fill.
module right_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SW-1:0]    amt,
    input  logic             op,
    output logic [WIDTH-1:0] y
);

    logic             fill_s;
    logic [WIDTH-1:0] acc_s;

    // Shift by each power of two selected in amt, backfilling with fill_s.
    always_comb begin
        fill_s = op & a[WIDTH-1];
        acc_s  = a;
        for (int k = 0; k < SW; k++) begin
            acc_s = amt[k] ? ((acc_s >> (1 << k)) |
                              (fill_s ? ~({WIDTH{1'b1}} >> (1 << k)) : {WIDTH{1'b0}}))
                           : acc_s;
        end
        y = acc_s;
    end

endmodule

module shift_execute_stage #(
    parameter int WIDTH = 32,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       FUNCT,
    input  logic [SW-1:0]    SHAMT,
    input  logic [WIDTH-1:0] A,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             ERR,
    output logic             BUSY
);

    localparam logic [1:0] FUNCT_SLL = 2'b00;
    localparam logic [1:0] FUNCT_SRA = 2'b11;
    localparam logic [1:0] FUNCT_RSV = 2'b10;

    // Mirror a word end-for-end (bit i takes bit WIDTH-1-i).
    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [SW-1:0]    s1_shamt_r;
    logic             s1_left_r;
    logic             s1_arith_r;
    logic             s1_err_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_y_r;
    logic             s2_err_r;

    logic             s2_free_s;
    logic             s1_adv_s;
    logic             in_xfer_s;
    logic [WIDTH-1:0] shift_out_s;
    logic [WIDTH-1:0] result_s;

    right_barrel_shifter #(
        .WIDTH (WIDTH),
        .SW    (SW)
    ) u_shifter (
        .a   (s1_a_r),
        .amt (s1_shamt_r),
        .op  (s1_arith_r),
        .y   (shift_out_s)
    );

    // Handshake: S2 can take a new entry when empty or draining this cycle.
    always_comb begin
        s2_free_s = ~s2_valid_r | OUT_READY;
        s1_adv_s  = s1_valid_r & s2_free_s;
        IN_READY  = ~s1_valid_r | s2_free_s;
        in_xfer_s = IN_VALID & IN_READY;
    end

    // Undo the entry reversal for left shifts; reserved codes yield zero.
    always_comb begin
        if (s1_err_r) begin
            result_s = {WIDTH{1'b0}};
        end else if (s1_left_r) begin
            result_s = bit_reverse(shift_out_s);
        end else begin
            result_s = shift_out_s;
        end
    end

    // S1 register: load on input transfer, empty when advancing with no refill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_shamt_r <= {SW{1'b0}};
            s1_left_r  <= 1'b0;
            s1_arith_r <= 1'b0;
            s1_err_r   <= 1'b0;
        end else if (in_xfer_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= (FUNCT == FUNCT_SLL) ? bit_reverse(A) : A;
            s1_shamt_r <= SHAMT;
            s1_left_r  <= (FUNCT == FUNCT_SLL);
            s1_arith_r <= (FUNCT == FUNCT_SRA);
            s1_err_r   <= (FUNCT == FUNCT_RSV);
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // S2 register: load on S1 advance, empty when the consumer takes the result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_valid_r <= 1'b0;
            s2_y_r     <= {WIDTH{1'b0}};
            s2_err_r   <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r <= 1'b1;
            s2_y_r     <= result_s;
            s2_err_r   <= s1_err_r;
        end else if (OUT_READY) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Outputs come straight from the S2 flops.
    always_comb begin
        OUT_VALID = s2_valid_r;
        Y         = s2_y_r;
        ERR       = s2_err_r;
        BUSY      = s1_valid_r | s2_valid_r;
    end

endmodule

// File: tb/tb_shift_execute_stage.sv
// Testbench for shift_execute_stage: a transaction-level model (queue of
// accepted requests with their acceptance edge) predicts every output each
// cycle; directed cases pin literal results, then randomized traffic runs.
module tb_shift_execute_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  FUNCT;
    logic [4:0]  SHAMT;
    logic [31:0] A;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] Y;
    logic        ERR;
    logic        BUSY;

    shift_execute_stage #(.WIDTH(32)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .FUNCT     (FUNCT),
        .SHAMT     (SHAMT),
        .A         (A),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Y         (Y),
        .ERR       (ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] y;
        logic        err;
        int          tag;
    } ent_t;

    ent_t q[$];
    int   edge_k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of each FUNCT code.
    function automatic logic [31:0] ref_shift(input logic [1:0] f, input logic [4:0] s,
                                              input logic [31:0] a);
        case (f)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b11:   return $unsigned($signed(a) >>> s);
            default: return 32'd0;
        endcase
    endfunction

    // Per-cycle compare against the transaction model, then apply the
    // transfers that the coming rising edge will perform.
    always @(negedge CLK) begin
        logic exp_ov;
        logic exp_ir;
        ent_t e;
        if (RST) begin
            chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
            chk("rst_busy", 32'(BUSY), 32'd0);
            chk("rst_in_ready", 32'(IN_READY), 32'd1);
            chk("rst_y", Y, 32'd0);
            chk("rst_err", 32'(ERR), 32'd0);
            q.delete();
        end else begin
            exp_ov = (q.size() > 0) && (q[0].tag + 2 <= edge_k);
            exp_ir = !((q.size() == 2) && !OUT_READY);
            chk("out_valid", 32'(OUT_VALID), 32'(exp_ov));
            chk("in_ready", 32'(IN_READY), 32'(exp_ir));
            chk("busy", 32'(BUSY), 32'(q.size() > 0));
            if (exp_ov) begin
                chk("y", Y, q[0].y);
                chk("err", 32'(ERR), 32'(q[0].err));
                if (OUT_READY) begin
                    void'(q.pop_front());
                end
            end
            if (IN_VALID && exp_ir) begin
                e.y   = ref_shift(FUNCT, SHAMT, A);
                e.err = (FUNCT == 2'b10);
                e.tag = edge_k;
                q.push_back(e);
            end
        end
        edge_k++;
    end

    // Single request on an idle pipeline with literal expected result.
    task automatic pinned(input logic [1:0] f, input logic [4:0] s, input logic [31:0] a,
                          input logic [31:0] ey, input logic ee);
        OUT_READY = 1'b1;
        IN_VALID  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        FUNCT    = f;
        SHAMT    = s;
        A        = a;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        chk("pin_not_yet", 32'(OUT_VALID), 32'd0);
        @(posedge CLK);
        #1;
        chk("pin_valid", 32'(OUT_VALID), 32'd1);
        chk("pin_y", Y, ey);
        chk("pin_err", 32'(ERR), 32'(ee));
    endtask

    initial begin
        int acc;
        logic took;
        logic hold;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        FUNCT     = 2'b00;
        SHAMT     = 5'd0;
        A         = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        pinned(2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0);
        pinned(2'b00, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0);
        pinned(2'b11, 5'd4,  32'h8000_00F0, 32'hF800_000F, 1'b0);
        pinned(2'b01, 5'd4,  32'h8000_00F0, 32'h0800_000F, 1'b0);
        pinned(2'b11, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0);
        pinned(2'b11, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        pinned(2'b10, 5'd5,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        pinned(2'b01, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        pinned(2'b00, 5'd4,  32'h8765_4321, 32'h7654_3210, 1'b0);

        // Three back-to-back requests; the model checks order and IN_READY.
        for (int i = 0; i < 3; i++) begin
            FUNCT    = 2'(i);
            SHAMT    = 5'(i + 3);
            A        = 32'hC0DE_0000 + 32'(i);
            IN_VALID = 1'b1;
            chk("b2b_in_ready", 32'(IN_READY), 32'd1);
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Backpressure: four cycles of stall with a request always offered.
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        FUNCT     = 2'b11;
        SHAMT     = 5'd7;
        A         = $urandom;
        acc       = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            took = IN_READY;
            if (took) acc++;
            @(posedge CLK);
            #1;
            if (took) begin
                A     = $urandom;
                SHAMT = 5'($urandom);
            end
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(IN_READY), 32'd0);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        chk("bp_drained", 32'(BUSY), 32'd0);

        // Asynchronous reset with both stages full; nothing stale afterwards.
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        FUNCT     = 2'b01;
        SHAMT     = 5'd1;
        A         = 32'hDEAD_BEEF;
        repeat (3) @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        chk("full_before_rst", 32'(BUSY), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_ov", 32'(OUT_VALID), 32'd0);
        chk("async_rst_busy", 32'(BUSY), 32'd0);
        chk("async_rst_y", Y, 32'd0);
        chk("async_rst_ir", 32'(IN_READY), 32'd1);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("no_stale", 32'(OUT_VALID), 32'd0);

        // Randomized traffic; upstream holds a request until it is accepted.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            hold = IN_VALID && !IN_READY;
            @(posedge CLK);
            #1;
            OUT_READY = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                IN_VALID = ($urandom_range(0, 3) != 0);
                FUNCT    = 2'($urandom);
                case ($urandom_range(0, 3))
                    0:       SHAMT = 5'd0;
                    1:       SHAMT = 5'd31;
                    default: SHAMT = 5'($urandom);
                endcase
                A = ($urandom_range(0, 1) != 0) ? $urandom : {1'b1, 31'($urandom)};
            end
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("final_busy", 32'(BUSY), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
